// File: rtl/common.sv
// Project-wide constants shared by the pipeline control blocks.
package common;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/pipes.sv
// Pipeline-wide types: register index width and the hazard controller state.
package pipes;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    MDU_WAIT
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Signals between the pipeline datapath and the hazard unit.
// With HAZARD_PERF_EN the perf counter can also be seeded through perf_load/perf_value.
interface hazard_unit_if;
  import common::*;
  import pipes::*;

  creg_addr_t rs1_D;
  creg_addr_t rs2_D;
  creg_addr_t rd_E;
  logic       memread_E;
  logic       redirect_E;
  logic       mdu_req_E;
  logic       mdu_done;
  logic       dmem_req_M;
  logic       dmem_ack;

  logic stall_F, stall_D, stall_E, stall_M;
  logic reset_D, reset_E, reset_M, reset_W;
  logic [CNT_W-1:0] stall_cnt;

`ifdef HAZARD_PERF_EN
  logic             perf_load;
  logic [CNT_W-1:0] perf_value;
`endif

  modport master (
    output rs1_D, rs2_D, rd_E, memread_E, redirect_E,
    output mdu_req_E, mdu_done, dmem_req_M, dmem_ack,
`ifdef HAZARD_PERF_EN
    output perf_load, perf_value,
`endif
    input  stall_F, stall_D, stall_E, stall_M,
    input  reset_D, reset_E, reset_M, reset_W,
    input  stall_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rd_E, memread_E, redirect_E,
    input  mdu_req_E, mdu_done, dmem_req_M, dmem_ack,
`ifdef HAZARD_PERF_EN
    input  perf_load, perf_value,
`endif
    output stall_F, stall_D, stall_E, stall_M,
    output reset_D, reset_E, reset_M, reset_W,
    output stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: the load in Execute writes a register that Decode reads.
module hazard_detect
  import pipes::*;
(
  input  creg_addr_t rs1_D,
  input  creg_addr_t rs2_D,
  input  creg_addr_t rd_E,
  input  logic       memread_E,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer
  assign load_use = memread_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory/MDU wait FSM, redirect and load-use handling.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_EN.
module hazard_unit
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave hz
);

  hazard_state_t state, state_next;
  logic load_use;
  logic mem_hold;
  logic mdu_hold;
  logic mdu_pending;

  hazard_detect u_detect (
    .rs1_D     (hz.rs1_D),
    .rs2_D     (hz.rs2_D),
    .rd_E      (hz.rd_E),
    .memread_E (hz.memread_E),
    .load_use  (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Memory stalls freeze the whole pipe, so they outrank everything else and
  // any suppressed E-stage request is seen again once the memory acks.
  always_comb begin
    mem_hold    = 1'b0;
    mdu_pending = hz.mdu_req_E && !hz.mdu_done;
    state_next  = state;
    hz.stall_F  = 1'b0;
    hz.stall_D  = 1'b0;
    hz.stall_E  = 1'b0;
    hz.stall_M  = 1'b0;
    hz.reset_D  = 1'b0;
    hz.reset_E  = 1'b0;
    hz.reset_M  = 1'b0;
    hz.reset_W  = 1'b0;

    case (state)
      IDLE:     mem_hold = hz.dmem_req_M && !hz.dmem_ack;
      MEM_WAIT: mem_hold = !hz.dmem_ack;
      default:  mem_hold = 1'b0;
    endcase
    mdu_hold = !mem_hold && mdu_pending;

    case (state)
      IDLE: begin
        if (hz.dmem_req_M && !hz.dmem_ack) state_next = MEM_WAIT;
        else if (mdu_pending)              state_next = MDU_WAIT;
      end
      MEM_WAIT: begin
        if (hz.dmem_ack) state_next = mdu_pending ? MDU_WAIT : IDLE;
      end
      MDU_WAIT: begin
        if (!mdu_pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (mem_hold) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.stall_E = 1'b1;
      hz.stall_M = 1'b1;
      hz.reset_W = 1'b1;
    end else if (mdu_hold) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.stall_E = 1'b1;
      hz.reset_M = 1'b1;
    end else if (hz.redirect_E) begin
      hz.reset_D = 1'b1;
      hz.reset_E = 1'b1;
    end else if (load_use) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.reset_E = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (hz.perf_load)
      stall_cnt_q <= hz.perf_value;
    else if (hz.stall_F && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors with hand-computed controls.
// Counter expectations depend on whether HAZARD_PERF_EN is defined.
module tb_hazard_unit;
  import common::*;
  import pipes::*;

  // {stall_F, stall_D, stall_E, stall_M, reset_D, reset_E, reset_M, reset_W}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] MEMH = 8'b1111_0001;
  localparam logic [7:0] MDUH = 8'b1110_0010;
  localparam logic [7:0] LU   = 8'b1100_0100;
  localparam logic [7:0] RD   = 8'b0000_1100;

  typedef struct packed {
    logic [7:0]       bits;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  hazard_unit_if hz();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  task automatic push_expect(input logic [7:0] bits);
    exp_t e;
    e.bits = bits;
`ifdef HAZARD_PERF_EN
    e.cnt = model_cnt;
`else
    e.cnt = '0;
`endif
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive just after the rising edge, queue what the
  // outputs must be for this cycle, then advance the counter model.
  task automatic apply_stimulus(input logic rst_v, input creg_addr_t rs1, input creg_addr_t rs2,
                                input creg_addr_t rd, input logic memread, input logic redirect,
                                input logic mdu_req, input logic mdu_done, input logic dmem_req,
                                input logic dmem_ack, input logic [7:0] exp_bits);
    @(posedge clk);
    #1;
    reset         = rst_v;
    hz.rs1_D      = rs1;
    hz.rs2_D      = rs2;
    hz.rd_E       = rd;
    hz.memread_E  = memread;
    hz.redirect_E = redirect;
    hz.mdu_req_E  = mdu_req;
    hz.mdu_done   = mdu_done;
    hz.dmem_req_M = dmem_req;
    hz.dmem_ack   = dmem_ack;
`ifdef HAZARD_PERF_EN
    hz.perf_load  = 1'b0;
`endif
    if (!rst_v) model_cnt = '0;
    push_expect(exp_bits);
    if (rst_v && exp_bits[7] && (model_cnt != '1)) model_cnt = model_cnt + CNT_W'(1);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic preload_counter(input logic [CNT_W-1:0] value);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    hz.memread_E  = 1'b0;
    hz.redirect_E = 1'b0;
    hz.mdu_req_E  = 1'b0;
    hz.mdu_done   = 1'b0;
    hz.dmem_req_M = 1'b0;
    hz.dmem_ack   = 1'b0;
    hz.perf_load  = 1'b1;
    hz.perf_value = value;
    push_expect(NONE);
    model_cnt = value;
  endtask
`endif

  task automatic check_output(input exp_t e);
    logic [7:0] act;
    act = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M,
           hz.reset_D, hz.reset_E, hz.reset_M, hz.reset_W};
    checks++;
    if (act !== e.bits) begin
      failures++;
      $display("[TB] FAIL controls @%0t: got %b expected %b", $time, act, e.bits);
    end
    checks++;
    if (hz.stall_cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL stall_cnt @%0t: got %h expected %h", $time, hz.stall_cnt, e.cnt);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare mid-cycle whenever a prediction waits
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: bench did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset         = 1'b0;
    hz.rs1_D      = '0;
    hz.rs2_D      = '0;
    hz.rd_E       = '0;
    hz.memread_E  = 1'b0;
    hz.redirect_E = 1'b0;
    hz.mdu_req_E  = 1'b0;
    hz.mdu_done   = 1'b0;
    hz.dmem_req_M = 1'b0;
    hz.dmem_ack   = 1'b0;
`ifdef HAZARD_PERF_EN
    hz.perf_load  = 1'b0;
    hz.perf_value = '0;
`endif

    // rst, rs1, rs2, rd, memread, redirect, mdu_req, mdu_done, dmem_req, dmem_ack, expected
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // load-use on rs2, then rs1; x0 and non-matching indices never stall
    apply_stimulus(1, 3, 5, 5, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 3, 5, 5, 0, 0, 0, 0, 0, 0, NONE);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, NONE);
    apply_stimulus(1, 7, 2, 7, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 6, 8, 7, 1, 0, 0, 0, 0, 0, NONE);

    // redirect beats load-use
    apply_stimulus(1, 3, 5, 5, 1, 1, 0, 0, 0, 0, RD);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, RD);

    // memory wait, ack after 3 cycles
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // ack in the request cycle must not leave a wait state behind
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // redirect and load-use held off by memory, redirect honoured at ack
    apply_stimulus(1, 3, 5, 5, 1, 1, 0, 0, 1, 0, MEMH);
    apply_stimulus(1, 3, 5, 5, 1, 1, 0, 0, 1, 0, MEMH);
    apply_stimulus(1, 3, 5, 5, 1, 1, 0, 0, 1, 1, RD);
    apply_stimulus(1, 3, 5, 5, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // MDU wait outranks redirect and load-use
    apply_stimulus(1, 3, 5, 5, 1, 1, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // overlap: 2-cycle memory wait, then MDU_WAIT (memory request ignored there)
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    // reset mid-MDU_WAIT: back in IDLE, so a pending memory request wins
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, MEMH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, MDUH);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, NONE);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

`ifdef HAZARD_PERF_EN
    // counter saturation
    preload_counter(32'hFFFF_FFFE);
    apply_stimulus(1, 3, 5, 5, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 3, 5, 5, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 3, 5, 5, 1, 0, 0, 0, 0, 0, LU);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
`endif

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
